// File: rtl/avr_timer_ext.sv
// avr_timer_ext: down-counting I/O-bus timer with reload, one-shot/periodic mode, W1C overflow and irq.
// Latency: register writes and counter updates land on the edge ending the cycle; io_do is combinational.
// Backpressure: none; the bus strobes are always accepted. Optional prescaler via AVR_TIMER_PRESCALER_EN.
`timescale 1ns/1ps
module avr_timer_ext #(
   parameter int          WIDTH     = 16,
   parameter int unsigned LOAD_INIT = 23999,
   parameter bit          AUTOSTART = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_re,
   input  logic       io_we,
   input  logic [3:0] io_a,
   input  logic [7:0] io_di,
   output logic [7:0] io_do,
   output logic       irq,
   input  logic       ack
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] load;
   logic [WIDTH-9:0] snap;
   logic             ien;
   logic             oneshot;
   logic             run;
   logic             ovf;
   logic [2:0]       ps;

   logic             wr;
   logic             ctrl_wr;
   logic             start;
   logic             stop;
   logic             tick;
   logic             count_en;
   logic             term;
   logic             ovf_clr;
   logic [31:0]      cnt_view;
   logic [31:0]      load_view;
   logic [7:0]       rd;

   // A read strobe always wins over a simultaneous write strobe
   assign wr      = io_we & ~io_re;
   assign ctrl_wr = wr & (io_a == 4'h8);
   assign start   = ctrl_wr & io_di[5] & ~run;
   assign stop    = ctrl_wr & ~io_di[5];

`ifdef AVR_TIMER_PRESCALER_EN
   logic [7:0] presc;
   logic [7:0] ps_mask;

   assign ps_mask = ~(8'hFF << ps);
   assign tick    = run & ((presc & ps_mask) == ps_mask);

   // Free-running prescaler: cleared on start, frozen while stopped
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc <= 8'h00;
      else if (start)
         presc <= 8'h00;
      else if (run & ~stop)
         presc <= presc + 8'd1;
   end

   // Prescale select field of CTRL
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ps <= 3'b000;
      else if (ctrl_wr)
         ps <= io_di[2:0];
   end
`else
   assign tick = run;
   assign ps   = 3'b000;
`endif

   // A stop write on the same edge freezes the counter before it can tick
   assign count_en = tick & ~stop;
   assign term     = count_en & (cnt == '0);
   assign ovf_clr  = ack | (wr & (io_a == 4'h9) & io_di[7]);

   // CTRL flags; an explicit CTRL write overrides the one-shot self-stop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ien     <= 1'b0;
         oneshot <= 1'b0;
         run     <= AUTOSTART;
      end else if (ctrl_wr) begin
         ien     <= io_di[7];
         oneshot <= io_di[6];
         run     <= io_di[5];
      end else if (term & oneshot) begin
         run     <= 1'b0;
      end
   end

   // Counter: reload on start, decrement per tick, reload or hold at zero on terminal tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (start)
         cnt <= load;
      else if (count_en) begin
         if (cnt == '0)
            cnt <= oneshot ? '0 : load;
         else
            cnt <= cnt - WIDTH'(1);
      end
   end

   // Overflow flag: a terminal tick beats any clear on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (term)
         ovf <= 1'b1;
      else if (ovf_clr)
         ovf <= 1'b0;
   end

   // LOAD bytes; bytes beyond the counter width do not exist
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         load <= WIDTH'(LOAD_INIT);
      else if (wr) begin
         for (int i = 0; i < NB; i++) begin
            if (io_a == 4'(4 + i))
               load[i*8 +: 8] <= io_di;
         end
      end
   end

   // Reading CNT byte 0 freezes the upper bytes so a multi-cycle read is coherent
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         snap <= '0;
      else if (io_re && (io_a == 4'h0))
         snap <= cnt[WIDTH-1:8];
   end

   assign cnt_view  = 32'({snap, cnt[7:0]});
   assign load_view = 32'(load);

   // Read mux, forced to zero when no read strobe is present
   always_comb begin
      rd = 8'h00;
      case (io_a)
         4'h0, 4'h1, 4'h2, 4'h3: rd = cnt_view[{io_a[1:0], 3'b000} +: 8];
         4'h4, 4'h5, 4'h6, 4'h7: rd = load_view[{io_a[1:0], 3'b000} +: 8];
         4'h8:                   rd = {ien, oneshot, run, 2'b00, ps};
         4'h9:                   rd = {ovf, 7'b000_0000};
         default:                rd = 8'h00;
      endcase
      io_do = io_re ? rd : 8'h00;
   end

   assign irq = ien & ovf;

endmodule

// File: tb/tb_avr_timer_ext.sv
`timescale 1ns/1ps
module tb_avr_timer_ext;

   localparam int W = 16;

   logic       clk;
   logic       rst;
   logic       io_re, io_we, ack;
   logic [3:0] io_a;
   logic [7:0] io_di;
   logic [7:0] io_do;
   logic       irq;

   logic       b_re, b_we, b_ack;
   logic [3:0] b_a;
   logic [7:0] b_di;
   logic [7:0] b_do;
   logic       b_irq;

   int n_cmp = 0;
   int n_bad = 0;
   int edges = 0;
   logic [7:0] last_rd, last_b;

   avr_timer_ext #(.WIDTH(16), .LOAD_INIT(23999), .AUTOSTART(1'b1)) u_dut (
      .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
      .io_di(io_di), .io_do(io_do), .irq(irq), .ack(ack));

   avr_timer_ext #(.WIDTH(32), .LOAD_INIT(32'h01020304), .AUTOSTART(1'b0)) u_dut32 (
      .clk(clk), .rst(rst), .io_re(b_re), .io_we(b_we), .io_a(b_a),
      .io_di(b_di), .io_do(b_do), .irq(b_irq), .ack(b_ack));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (16-bit instance) ----------------
   int unsigned m_cnt, m_load, m_latch, m_ps, m_el;
   bit          m_run, m_ien, m_os, m_ovf;

   function automatic void m_reset();
      m_cnt = 0; m_load = 23999; m_latch = 0; m_ps = 0; m_el = 0;
      m_run = 1'b1; m_ien = 1'b0; m_os = 1'b0; m_ovf = 1'b0;
   endfunction

   function automatic logic [7:0] m_read(input logic [3:0] a);
      int unsigned v;
      v = 0;
      if (a == 0)      v = m_cnt & 255;
      else if (a <= 3) v = (a < W/8) ? ((m_latch >> (8*a)) & 255) : 0;
      else if (a <= 7) v = ((a - 4) < W/8) ? ((m_load >> (8*(a-4))) & 255) : 0;
      else if (a == 8) v = m_ien*128 + m_os*64 + m_run*32 + m_ps;
      else if (a == 9) v = m_ovf*128;
      return v[7:0];
   endfunction

   task automatic m_step(input bit re, input bit we, input logic [3:0] a,
                         input logic [7:0] di, input bit ak);
      bit wr, is_ctrl, stop, start, tick, adv, hit;
      int unsigned div, sh;
      int unsigned n_cnt, n_load, n_latch, n_el, n_ps;
      bit n_run, n_ovf, n_ien, n_os;
      wr      = we && !re;
      is_ctrl = wr && (a == 8);
      stop    = is_ctrl && !di[5];
      start   = is_ctrl && di[5] && !m_run;
`ifdef AVR_TIMER_PRESCALER_EN
      div = 1 << m_ps;
`else
      div = 1;
`endif
      tick = m_run && (((m_el + 1) % div) == 0);
      adv  = tick && !stop;
      hit  = adv && (m_cnt == 0);
      n_cnt = m_cnt; n_load = m_load; n_latch = m_latch; n_el = m_el; n_ps = m_ps;
      n_run = m_run; n_ovf = m_ovf; n_ien = m_ien; n_os = m_os;
      if (re && a == 0) n_latch = m_cnt;
      if (adv) begin
         if (m_cnt == 0) begin
            n_ovf = 1'b1;
            if (m_os) n_run = 1'b0;
            else      n_cnt = m_load;
         end else
            n_cnt = m_cnt - 1;
      end
      if (!hit && (ak || (wr && a == 9 && di[7]))) n_ovf = 1'b0;
      if (is_ctrl) begin
         n_ien = di[7]; n_os = di[6]; n_run = di[5];
`ifdef AVR_TIMER_PRESCALER_EN
         n_ps = di[2:0];
`endif
      end
      if (start) begin
         n_cnt = m_load; n_el = 0;
      end else if (m_run && !stop)
         n_el = m_el + 1;
      if (wr && a >= 4 && (a - 4) < W/8) begin
         sh = 8 * (a - 4);
         n_load = (m_load & ~(32'hFF << sh)) | (32'(di) << sh);
      end
      m_cnt = n_cnt; m_load = n_load; m_latch = n_latch; m_el = n_el; m_ps = n_ps;
      m_run = n_run; m_ovf = n_ovf; m_ien = n_ien; m_os = n_os;
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edges);
      end
   endtask

   task automatic cycle(input bit re, input bit we, input logic [3:0] a,
                        input logic [7:0] di, input bit ak);
      io_re = re; io_we = we; io_a = a; io_di = di; ack = ak;
      #3;
      last_rd = io_do;
      last_b  = b_do;
      chk("io_do", io_do, re ? m_read(a) : 8'h00);
      @(posedge clk);
      m_step(re, we, a, di, ak);
      edges++;
      #1;
      chk("irq", irq, m_ien & m_ovf);
   endtask

   task automatic idle();                                  cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b0); endtask
   task automatic wrr(input logic [3:0] a, input logic [7:0] d); cycle(1'b0, 1'b1, a, d, 1'b0);  endtask
   task automatic rdr(input logic [3:0] a);                cycle(1'b1, 1'b0, a, 8'h00, 1'b0);    endtask
   task automatic acks();                                  cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1); endtask

   task automatic cyc32(input bit re, input bit we, input logic [3:0] a, input logic [7:0] d);
      b_re = re; b_we = we; b_a = a; b_di = d;
      idle();
      b_re = 1'b0; b_we = 1'b0; b_a = 4'h0; b_di = 8'h00;
   endtask

   task automatic wait_irq(input string nm, input int bound);
      int i;
      i = 0;
      do begin
         idle();
         i++;
      end while (irq !== 1'b1 && i < bound);
      chk(nm, irq, 1);
   endtask

   typedef struct {
      bit         re;
      logic [3:0] a;
      logic [7:0] e16;
      logic [7:0] e32;
   } rv_t;

   rv_t tv[17];

   initial begin
      int k, e1;
      logic [31:0] v;
      logic [7:0] exp_ctrl;
      int exp_per;

      rst = 1'b0;
      io_re = 1'b0; io_we = 1'b0; io_a = 4'h0; io_di = 8'h00; ack = 1'b0;
      b_re = 1'b0; b_we = 1'b0; b_a = 4'h0; b_di = 8'h00; b_ack = 1'b0;
      last_rd = 8'h00; last_b = 8'h00;

      for (int i = 0; i < 16; i++) tv[i] = '{1'b1, 4'(i), 8'h00, 8'h00};
      tv[4].e16 = 8'hBF; tv[5].e16 = 8'h5D; tv[8].e16 = 8'h20;
      tv[4].e32 = 8'h04; tv[5].e32 = 8'h03; tv[6].e32 = 8'h02; tv[7].e32 = 8'h01;
      tv[16] = '{1'b0, 4'h4, 8'h00, 8'h00};

      // reset-state register map, read while reset is held
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 17; i++) begin
         io_re = tv[i].re; b_re = tv[i].re; io_a = tv[i].a; b_a = tv[i].a;
         #2;
         chk($sformatf("rst_rd16_a%0h_re%0d", tv[i].a, tv[i].re), io_do, tv[i].e16);
         chk($sformatf("rst_rd32_a%0h_re%0d", tv[i].a, tv[i].re), b_do, tv[i].e32);
      end
      chk("rst_irq", irq, 0);
      io_re = 1'b0; b_re = 1'b0; io_a = 4'h0; b_a = 4'h0;
      @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
      edges = 0;

      // autostart: first tick reloads and sets OVF without irq
      idle();
      rdr(4'h9);            chk("autostart_ovf", last_rd, 8'h80);
      chk("autostart_noirq", irq, 0);
      wrr(4'h9, 8'h7F);
      cycle(1'b1, 1'b1, 4'h9, 8'h80, 1'b0);
      rdr(4'h9);            chk("w1c_zero_and_rw_noop", last_rd, 8'h80);
      wrr(4'h9, 8'h80);
      rdr(4'h9);            chk("w1c_clear", last_rd, 8'h00);
      wrr(4'h8, 8'hA0);

      // 32-bit coherent snapshot read
      cyc32(1'b0, 1'b1, 4'h8, 8'h20);
      k = $urandom_range(3, 40);
      repeat (k) idle();
      cyc32(1'b1, 1'b0, 4'h0, 8'h00); v[7:0] = last_b;
      idle();
      cyc32(1'b1, 1'b0, 4'h1, 8'h00); v[15:8] = last_b;
      idle();
      cyc32(1'b1, 1'b0, 4'h2, 8'h00); v[23:16] = last_b;
      idle();
      cyc32(1'b1, 1'b0, 4'h3, 8'h00); v[31:24] = last_b;
      chk("snap32_value", v, 32'(32'h01020304 - k));
      chk("snap32_le_load", {31'd0, (v <= 32'h01020304)}, 1);

      // periodic 24000-clock period from the autostart reload
      wait_irq("period_timeout", 30000);
      chk("period_24000", edges, 24001);
      acks();               chk("ack_fall", irq, 0);

      // ack on the exact terminal-tick edge
      wrr(4'h8, 8'h80); wrr(4'h4, 8'h03); wrr(4'h5, 8'h00); wrr(4'h9, 8'h80);
      wrr(4'h8, 8'hA0);
      for (int i = 0; i < 3; i++) begin idle(); chk("at_pre_irq", irq, 0); end
      acks();               chk("ack_on_terminal", irq, 1);
      idle();               chk("ovf_kept", irq, 1);
      rdr(4'h9);            chk("ovf_kept_rd", last_rd, 8'h80);
      acks();               chk("ack_after_terminal", irq, 0);

      // one-shot
      wrr(4'h8, 8'h80); wrr(4'h4, 8'h05); wrr(4'h9, 8'h80);
      wrr(4'h8, 8'hE0);
      for (int i = 0; i < 5; i++) begin idle(); chk("os_early", irq, 0); end
      idle();               chk("oneshot_irq_at_6", irq, 1);
      for (int i = 0; i < 50; i++) begin
         rdr(4'h8);         chk("os_run_cleared", last_rd, 8'hC0);
         rdr(4'h0);         chk("os_cnt_zero", last_rd, 8'h00);
      end

      // prescaler
`ifdef AVR_TIMER_PRESCALER_EN
      exp_ctrl = 8'hA3; exp_per = 16;
`else
      exp_ctrl = 8'hA0; exp_per = 2;
`endif
      wrr(4'h8, 8'h80); wrr(4'h4, 8'h01); wrr(4'h9, 8'h80);
      wrr(4'h8, 8'hA3);
      rdr(4'h8);            chk("ps_ctrl_rd", last_rd, exp_ctrl);
      wait_irq("ps_first_timeout", 100);
      e1 = edges;
      acks();               chk("ps_ack", irq, 0);
      wait_irq("ps_second_timeout", 100);
      chk("ps_period", edges - e1, exp_per);

      // randomized traffic against the model
      for (int n = 0; n < 2500; n++) begin
         bit r_re, r_we, r_ak;
         logic [3:0] r_a;
         logic [7:0] r_di;
         r_re = ($urandom % 2) == 1;
         r_we = ($urandom % 3) == 0;
         r_a  = 4'($urandom % 16);
         r_di = 8'($urandom);
         if (r_a == 4'h5) r_di = 8'($urandom % 2);
         if (r_a == 4'h8) r_di[5] = ($urandom % 4) != 0;
         r_ak = ($urandom % 8) == 0;
         cycle(r_re, r_we, r_a, r_di, r_ak);
      end

      // asynchronous reset mid-count with CNT=0x1234 and irq high
      wrr(4'h8, 8'h80); wrr(4'h4, 8'h00); wrr(4'h5, 8'h00); wrr(4'h8, 8'hA0);
      idle();               chk("pre_rst_irq", irq, 1);
      wrr(4'h8, 8'h80); wrr(4'h4, 8'h36); wrr(4'h5, 8'h12); wrr(4'h8, 8'hA0);
      idle(); idle();
      io_re = 1'b1; io_a = 4'h0;
      #1 chk("cnt_1234_lo", io_do, 8'h34);
      chk("pre_rst_irq2", irq, 1);
      rst = 1'b1;
      #1 chk("rst_async_irq", irq, 0);
      chk("rst_async_cnt", io_do, 8'h00);
      io_a = 4'h9;
      #1 chk("rst_async_ovf", io_do, 8'h00);
      io_a = 4'h4;
      #1 chk("rst_async_load", io_do, 8'hBF);
      io_re = 1'b0; io_a = 4'h0;
      @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
      idle();
      rdr(4'h9);            chk("post_rst_autostart", last_rd, 8'h80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
